// File: rtl/serial_add_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : slip_seradd_pkg                                            |
// | Shared types and constants for the serial add scheduler.             |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
package slip_seradd_pkg;

  // Scheduler phases: arbitration, bit-serial add, result publish.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Number of requesters sharing the serial datapath.
  localparam int NREQ = 2;

  // Width of the bit counter for a given operand width.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_add_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : serial_add_sched_if                                      |
// | Request/operand/result bundle of the serial add scheduler.           |
// | Rev       : 1.0                                                      |
// +----------------------------------------------------------------------+
interface serial_add_sched_if
  import slip_seradd_pkg::*;
#(
  parameter int WIDTH = 16
);

  logic [NREQ-1:0]  REQ;
  logic [WIDTH-1:0] X0;
  logic [WIDTH-1:0] Y0;
  logic [WIDTH-1:0] X1;
  logic [WIDTH-1:0] Y1;
  logic [NREQ-1:0]  GNT;
  logic [NREQ-1:0]  DONE;
  logic [WIDTH-1:0] SUM;
  logic             COUT;
  logic             BUSY;

  // Requester side: drives requests and operands, observes results.
  modport master (
    output REQ, X0, Y0, X1, Y1,
    input  GNT, DONE, SUM, COUT, BUSY
  );

  // Scheduler side.
  modport slave (
    input  REQ, X0, Y0, X1, Y1,
    output GNT, DONE, SUM, COUT, BUSY
  );

endinterface
`default_nettype wire

// File: rtl/serial_add_sched_fa_bit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : serial_fa_bit                                               |
// | Combinational 1-bit full adder: two half-add cells plus carry OR.    |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module serial_fa_bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_p;
  logic w_g1;
  logic w_g2;

  // First half-add cell: x + y.
  assign w_p  = x ^ y;
  assign w_g1 = x & y;

  // Second half-add cell: partial sum + carry in.
  assign s    = w_p ^ cin;
  assign w_g2 = w_p & cin;

  // Either half-add cell can generate the carry.
  assign cout = w_g1 | w_g2;

endmodule
`default_nettype wire

// File: rtl/serial_add_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : serial_add_sched                                            |
// | Round-robin scheduler sharing one bit-serial adder between two       |
// | requesters; operands shift LSB first through a 1-bit full add.       |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module serial_add_sched
  import slip_seradd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              MasterClock,
  input  logic              RESETL,
  serial_add_sched_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic             r_ptr;
  logic             r_owner;
  logic [WIDTH-1:0] r_xs;
  logic [WIDTH-1:0] r_ys;
  logic [WIDTH-1:0] r_rs;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_done;
  logic             r_busy;

  logic             w_win;
  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_rs_next;

  // Round-robin pick: a lone request always wins, a tie goes to the pointer.
  always_comb begin
    w_win = r_ptr;
    if (bus.REQ != 2'b11) w_win = bus.REQ[1];
  end

  serial_fa_bit u_fa (
    .x    (r_xs[0]),
    .y    (r_ys[0]),
    .cin  (r_c),
    .s    (w_s),
    .cout (w_c)
  );

  // New sum bit enters from the MSB side so bit 0 ends up at the LSB.
  assign w_rs_next = (r_rs >> 1) | {w_s, {(WIDTH-1){1'b0}}};

  // Scheduler FSM, serial datapath and registered outputs.
  always_ff @(posedge MasterClock) begin
    if (!RESETL) begin
      r_state <= IDLE;
      r_ptr   <= 1'b0;
      r_owner <= 1'b0;
      r_xs    <= '0;
      r_ys    <= '0;
      r_rs    <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (bus.REQ != '0) begin
            r_owner <= w_win;
            r_xs    <= w_win ? bus.X1 : bus.X0;
            r_ys    <= w_win ? bus.Y1 : bus.Y0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_gnt   <= w_win ? 2'b10 : 2'b01;
            r_ptr   <= ~w_win;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_rs  <= w_rs_next;
          r_xs  <= r_xs >> 1;
          r_ys  <= r_ys >> 1;
          r_c   <= w_c;
          r_cnt <= r_cnt + 1'b1;
          // The result is published on the edge that enters FINISH so that
          // SUM/COUT and DONE are all valid during the FINISH cycle.
          if (r_cnt == C_LAST) begin
            r_sum   <= w_rs_next;
            r_cout  <= w_c;
            r_done  <= r_owner ? 2'b10 : 2'b01;
            r_state <= FINISH;
          end
        end
        FINISH: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.GNT  = r_gnt;
  assign bus.DONE = r_done;
  assign bus.SUM  = r_sum;
  assign bus.COUT = r_cout;
  assign bus.BUSY = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_serial_add_sched                                         |
// | Self-checking bench: transaction-level timeline model plus directed  |
// | and randomized requests.                                             |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_serial_add_sched;

  localparam int W = 16;

  logic master_clock;
  logic resetl;
  int   cyc;
  int   checks;
  int   fails;

  serial_add_sched_if #(.WIDTH(W)) bus ();

  serial_add_sched #(.WIDTH(W)) dut (
    .MasterClock (master_clock),
    .RESETL      (resetl),
    .bus         (bus)
  );

  initial begin
    master_clock = 1'b0;
    forever #5 master_clock = ~master_clock;
  end

  always @(posedge master_clock) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s actual=%h required=%h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    checks = checks + 1;
    fails  = fails + 1;
    $display("FAIL %s actual=no-pulse required=pulse cycle=%0d", nm, cyc);
  endtask

  // Timeline model: a granted transaction occupies W+1 cycles after the
  // arbitration edge; DONE appears W cycles after GNT.
  bit           started;
  int           m_left;
  int           m_own;
  bit           m_ptr;
  logic [W:0]   m_res;
  logic [1:0]   e_gnt;
  logic [1:0]   e_done;
  logic [W-1:0] e_sum;
  logic         e_cout;
  logic         e_busy;

  always @(posedge master_clock) begin
    started = 1'b1;
    e_gnt   = 2'b00;
    e_done  = 2'b00;
    if (!resetl) begin
      m_left = 0;
      m_ptr  = 1'b0;
      e_sum  = '0;
      e_cout = 1'b0;
      e_busy = 1'b0;
    end else if (m_left == 0) begin
      e_busy = 1'b0;
      if (bus.REQ != 2'b00) begin
        if (bus.REQ == 2'b11) m_own = int'(m_ptr);
        else m_own = bus.REQ[1] ? 1 : 0;
        m_res  = (m_own == 1) ? ({1'b0, bus.X1} + {1'b0, bus.Y1})
                              : ({1'b0, bus.X0} + {1'b0, bus.Y0});
        e_gnt  = (m_own == 1) ? 2'b10 : 2'b01;
        m_ptr  = (m_own == 0);
        m_left = W + 1;
        e_busy = 1'b1;
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 1) begin
        e_done = (m_own == 1) ? 2'b10 : 2'b01;
        e_sum  = m_res[W-1:0];
        e_cout = m_res[W];
      end
      if (m_left == 0) e_busy = 1'b0;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge master_clock) begin
    if (started) begin
      chk("gnt",  32'(bus.GNT),  32'(e_gnt));
      chk("done", 32'(bus.DONE), 32'(e_done));
      chk("sum",  32'(bus.SUM),  32'(e_sum));
      chk("cout", 32'(bus.COUT), 32'(e_cout));
      chk("busy", 32'(bus.BUSY), 32'(e_busy));
    end
  end

  task automatic wait_gnt(output int own, output int at);
    bit seen;
    seen = 1'b0;
    own  = -1;
    at   = -1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge master_clock);
      if (bus.GNT != 2'b00) begin
        seen = 1'b1;
        own  = bus.GNT[1] ? 1 : 0;
        at   = cyc;
      end
    end
    if (!seen) timeout("gnt_wait");
  endtask

  task automatic wait_done(output int own, output int at);
    bit seen;
    seen = 1'b0;
    own  = -1;
    at   = -1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge master_clock);
      if (bus.DONE != 2'b00) begin
        seen = 1'b1;
        own  = bus.DONE[1] ? 1 : 0;
        at   = cyc;
      end
    end
    if (!seen) timeout("done_wait");
  endtask

  // One request from a single requester; returns grant/done latencies.
  task automatic txn(input int idx, input logic [W-1:0] x, input logic [W-1:0] y,
                     output int gown, output int downr, output int lat_g, output int lat_d);
    int t0;
    int tg;
    int td;
    @(posedge master_clock);
    #1;
    if (idx == 1) begin bus.X1 = x; bus.Y1 = y; bus.REQ = 2'b10; end
    else          begin bus.X0 = x; bus.Y0 = y; bus.REQ = 2'b01; end
    t0 = cyc;
    wait_gnt(gown, tg);
    bus.REQ = 2'b00;
    wait_done(downr, td);
    lat_g = tg - t0;
    lat_d = td - t0;
  endtask

  function automatic logic [W-1:0] rop();
    case ($urandom % 4)
      0:       return {W{1'b1}};
      1:       return W'($urandom % 4);
      default: return W'($urandom);
    endcase
  endfunction

  int           go;
  int           dn;
  int           lg;
  int           ld;
  int           tg;
  int           td;
  int           gown[5];
  int           gat[5];
  logic [W-1:0] dsum[5];
  logic         dcout[5];
  logic [W-1:0] rx;
  logic [W-1:0] ry;
  logic [W:0]   rref;
  bit           seen;

  initial begin
    checks = 0;
    fails  = 0;
    cyc    = 0;
    started = 1'b0;
    resetl = 1'b0;
    bus.REQ = 2'b00;
    bus.X0 = '0; bus.Y0 = '0; bus.X1 = '0; bus.Y1 = '0;
    repeat (3) @(posedge master_clock);
    #1 resetl = 1'b1;
    @(negedge master_clock);
    chk("reset_sum",  32'(bus.SUM),  32'h0);
    chk("reset_busy", 32'(bus.BUSY), 32'h0);

    // Single add from requester 0.
    txn(0, 16'h1234, 16'h4321, go, dn, lg, ld);
    chk("single_gnt_owner", 32'(go), 32'd0);
    chk("single_gnt_lat",   32'(lg), 32'd1);
    chk("single_done_owner", 32'(dn), 32'd0);
    chk("single_done_lat",  32'(ld), 32'd17);
    chk("single_sum",  32'(bus.SUM),  32'h5555);
    chk("single_cout", 32'(bus.COUT), 32'h0);
    @(negedge master_clock);
    chk("single_busy_after", 32'(bus.BUSY), 32'h0);

    // Carry ripples through every bit.
    txn(1, 16'hFFFF, 16'h0001, go, dn, lg, ld);
    chk("carry_done_owner", 32'(dn), 32'd1);
    chk("carry_sum",  32'(bus.SUM),  32'h0000);
    chk("carry_cout", 32'(bus.COUT), 32'h1);

    // Contention and fairness: both requests held from reset.
    @(posedge master_clock);
    #1;
    resetl = 1'b0;
    bus.X0 = 16'h0001; bus.Y0 = 16'h0002;
    bus.X1 = 16'h8000; bus.Y1 = 16'h8000;
    bus.REQ = 2'b11;
    repeat (2) @(posedge master_clock);
    #1 resetl = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(gown[i], gat[i]);
      if (i == 4) bus.REQ = 2'b00;
      wait_done(dn, td);
      dsum[i]  = bus.SUM;
      dcout[i] = bus.COUT;
    end
    for (int i = 0; i < 5; i++) chk("fair_owner", 32'(gown[i]), 32'(i % 2));
    chk("contend_gap",   32'(gat[1] - gat[0]), 32'd18);
    chk("contend_sum0",  32'(dsum[0]),  32'h0003);
    chk("contend_cout0", 32'(dcout[0]), 32'h0);
    chk("contend_sum1",  32'(dsum[1]),  32'h0000);
    chk("contend_cout1", 32'(dcout[1]), 32'h1);

    // Reset in the middle of a shift aborts without a DONE.
    @(posedge master_clock);
    #1;
    bus.X0 = 16'hA5A5; bus.Y0 = 16'h1111; bus.REQ = 2'b01;
    wait_gnt(go, tg);
    bus.REQ = 2'b00;
    repeat (7) @(posedge master_clock);
    #1 resetl = 1'b0;
    @(posedge master_clock);
    #1 resetl = 1'b1;
    @(negedge master_clock);
    chk("abort_gnt",  32'(bus.GNT),  32'h0);
    chk("abort_done", 32'(bus.DONE), 32'h0);
    chk("abort_sum",  32'(bus.SUM),  32'h0);
    chk("abort_cout", 32'(bus.COUT), 32'h0);
    chk("abort_busy", 32'(bus.BUSY), 32'h0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge master_clock);
      if (bus.DONE != 2'b00) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'h0);
    rx = rop();
    ry = rop();
    rref = {1'b0, rx} + {1'b0, ry};
    txn(0, rx, ry, go, dn, lg, ld);
    chk("after_abort_sum",  32'(bus.SUM),  32'(rref[W-1:0]));
    chk("after_abort_cout", 32'(bus.COUT), 32'(rref[W]));

    // Result held while idle.
    txn(0, 16'h1234, 16'h4321, go, dn, lg, ld);
    repeat (50) @(negedge master_clock);
    chk("hold_sum",  32'(bus.SUM),  32'h5555);
    chk("hold_cout", 32'(bus.COUT), 32'h0);

    // Randomized request mix; the model checks every cycle.
    for (int it = 0; it < 40; it++) begin
      if (!bus.REQ[0] && ($urandom % 2 == 1)) begin
        bus.X0 = rop(); bus.Y0 = rop(); bus.REQ[0] = 1'b1;
      end
      if (!bus.REQ[1] && ($urandom % 2 == 1)) begin
        bus.X1 = rop(); bus.Y1 = rop(); bus.REQ[1] = 1'b1;
      end
      if (bus.REQ == 2'b00) begin
        bus.X1 = rop(); bus.Y1 = rop(); bus.REQ[1] = 1'b1;
      end
      wait_gnt(go, tg);
      if (go >= 0) bus.REQ[go] = 1'b0;
      wait_done(dn, td);
      chk("rand_done_owner", 32'(dn), 32'(go));
      repeat ($urandom_range(0, 2)) @(negedge master_clock);
    end
    bus.REQ = 2'b00;
    repeat (25) @(negedge master_clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
